// File: rtl/divider_8by4_if.sv
// ---------------------------------------------------------------------------
// divider_8by4_if
// Request/response bundle for the 8-by-4 unsigned divider.
//
// Signals:
//   start    : request pulse, requester -> divider
//   a        : 8-bit unsigned dividend, requester -> divider
//   b        : 4-bit unsigned divisor, requester -> divider
//   busy     : division in progress, divider -> requester
//   done     : one-cycle result-valid pulse, divider -> requester
//   quotient : 8-bit unsigned quotient, divider -> requester
//   rem      : 4-bit unsigned remainder, divider -> requester
//   dbz      : divide-by-zero flag, divider -> requester
//
// Modports:
//   master : the requester (drives start/a/b)
//   slave  : the divider (drives busy/done/quotient/rem/dbz)
// ---------------------------------------------------------------------------
interface divider_8by4_if;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] rem;
  logic       dbz;

  modport master (
    output start, a, b,
    input  busy, done, quotient, rem, dbz
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, rem, dbz
  );
endinterface

// File: rtl/divider_8by4.sv
// ---------------------------------------------------------------------------
// divider_8by4
// Restoring shift-subtract divider: 8-bit unsigned dividend by 4-bit unsigned
// divisor, one quotient bit per clock, MSB first. A request accepted at edge
// E0 completes at E8 and done pulses for the cycle after E8.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : divider_8by4_if.slave (start/a/b in, busy/done/quotient/rem/dbz out)
//
// Configuration macro:
//   DIVIDER_DBZ_DETECT_EN
//     defined   : b == 0 finishes one edge after acceptance with
//                 quotient = 8'hFF, rem = 0 and dbz = 1
//     undefined : b == 0 runs the normal 8-iteration path
//                 (quotient = 8'hFF, rem = a[3:0]); dbz is tied low
// ---------------------------------------------------------------------------
module divider_8by4 (
  input logic           clk,
  input logic           rst_n,
  divider_8by4_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_dividend;
  logic [3:0] r_divisor;
  logic [3:0] r_part;
  logic [6:0] r_q;
  logic [2:0] r_count;
  logic [7:0] r_quotient;
  logic [3:0] r_rem;

  logic       w_accept;
  logic       w_finish;
  logic       w_busy;
  logic       w_done;
  logic [4:0] w_trial;
  logic       w_qbit;
  logic [3:0] w_part_next;
  logic [7:0] w_result_q;
  logic [3:0] w_result_rem;

`ifdef DIVIDER_DBZ_DETECT_EN
  logic       r_dbz;
  logic       w_zero_div;
`endif

  // A new request is only taken when no division is in flight; DONE accepts
  // too so that back-to-back requests lose no cycle.
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // One restoring step. The 5-bit trial remainder is the previous remainder
  // shifted left with the next dividend bit. Only 4 bits are kept: after the
  // compare it is always below b, and for b == 0 the dropped MSB would be
  // shifted out on the next step anyway.
  assign w_trial     = {r_part, r_dividend[7]};
  assign w_qbit      = (w_trial >= {1'b0, r_divisor});
  assign w_part_next = w_qbit ? 4'(w_trial - {1'b0, r_divisor}) : w_trial[3:0];

`ifdef DIVIDER_DBZ_DETECT_EN
  // A zero divisor short-circuits to a saturated result on the first RUN edge.
  assign w_zero_div   = (r_divisor == 4'h0);
  assign w_finish     = (r_state == S_RUN) && ((r_count == 3'd0) || w_zero_div);
  assign w_result_q   = w_zero_div ? 8'hFF : {r_q, w_qbit};
  assign w_result_rem = w_zero_div ? 4'h0  : w_part_next;
`else
  assign w_finish     = (r_state == S_RUN) && (r_count == 3'd0);
  assign w_result_q   = {r_q, w_qbit};
  assign w_result_rem = w_part_next;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status decode. busy covers the eight RUN cycles, done is
  // the single DONE cycle.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_finish) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operands are captured on acceptance so later changes on a/b
  // are invisible; the published results only change on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= 8'h00;
      r_divisor  <= 4'h0;
      r_part     <= 4'h0;
      r_q        <= 7'h00;
      r_count    <= 3'd0;
      r_quotient <= 8'h00;
      r_rem      <= 4'h0;
`ifdef DIVIDER_DBZ_DETECT_EN
      r_dbz      <= 1'b0;
`endif
    end else if (w_accept) begin
      r_dividend <= bus.a;
      r_divisor  <= bus.b;
      r_part     <= 4'h0;
      r_q        <= 7'h00;
      r_count    <= 3'd7;
`ifdef DIVIDER_DBZ_DETECT_EN
      r_dbz      <= 1'b0;
`endif
    end else if (r_state == S_RUN) begin
      r_dividend <= {r_dividend[6:0], 1'b0};
      r_part     <= w_part_next;
      r_q        <= {r_q[5:0], w_qbit};
      if (r_count != 3'd0) begin
        r_count <= r_count - 3'd1;
      end
      if (w_finish) begin
        r_quotient <= w_result_q;
        r_rem      <= w_result_rem;
`ifdef DIVIDER_DBZ_DETECT_EN
        r_dbz      <= w_zero_div;
`endif
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.quotient = r_quotient;
  assign bus.rem      = r_rem;
`ifdef DIVIDER_DBZ_DETECT_EN
  assign bus.dbz      = r_dbz;
`else
  assign bus.dbz      = 1'b0;
`endif

endmodule

// File: tb/tb_divider_8by4.sv
// ---------------------------------------------------------------------------
// tb_divider_8by4
// Self-checking bench for divider_8by4. Expected results are pushed to a
// scoreboard queue when a request is driven and popped when done appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours DIVIDER_DBZ_DETECT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_divider_8by4;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] rm;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  divider_8by4_if bus ();

  divider_8by4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference behaviour of the divider, including divide-by-zero handling.
  function automatic exp_t model(input logic [7:0] av, input logic [3:0] bv);
    exp_t       e;
    logic [7:0] m;
    if (bv == 4'h0) begin
`ifdef DIVIDER_DBZ_DETECT_EN
      e.q  = 8'hFF;
      e.rm = 4'h0;
      e.z  = 1'b1;
`else
      e.q  = 8'hFF;
      e.rm = av[3:0];
      e.z  = 1'b0;
`endif
    end else begin
      e.q  = av / {4'h0, bv};
      m    = av % {4'h0, bv};
      e.rm = m[3:0];
      e.z  = 1'b0;
    end
    return e;
  endfunction

  // Present one start pulse; returns at the falling edge after acceptance.
  task automatic drive_start(input logic [7:0] av, input logic [3:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    sb.push_back(model(av, bv));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded to 20.
  task automatic wait_done(output int cycles, output bit timeout);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    timeout = (bus.done !== 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", bus.done); end
    checks++; if (bus.quotient !== 8'h00) begin errors++; $display("[TB] FAIL reset quotient: got %h expected 00", bus.quotient); end
    checks++; if (bus.rem !== 4'h0) begin errors++; $display("[TB] FAIL reset rem: got %h expected 0", bus.rem); end
    checks++; if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL reset dbz: got %b expected 0", bus.dbz); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int   cyc;
    bit   to;
    exp_t e;
    drive_start(8'd66, 4'd6);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic busy after start: got %b expected 1", bus.busy); end
    wait_done(cyc, to);
    e = sb.pop_front();
    checks++; if (to || cyc != 8) begin errors++; $display("[TB] FAIL basic latency: got %0d edges (timeout %0d) expected 8", cyc, to); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic busy at done: got %b expected 0", bus.busy); end
    checks++; if (bus.quotient !== e.q) begin errors++; $display("[TB] FAIL basic quotient: got %0d expected %0d", bus.quotient, e.q); end
    checks++; if (bus.rem !== e.rm) begin errors++; $display("[TB] FAIL basic rem: got %0d expected %0d", bus.rem, e.rm); end
    checks++; if (bus.dbz !== e.z) begin errors++; $display("[TB] FAIL basic dbz: got %b expected %b", bus.dbz, e.z); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic done width: got %b expected 0", bus.done); end
    @(negedge clk);
    checks++; if (bus.quotient !== e.q) begin errors++; $display("[TB] FAIL basic quotient hold: got %0d expected %0d", bus.quotient, e.q); end
    checks++; if (bus.rem !== e.rm) begin errors++; $display("[TB] FAIL basic rem hold: got %0d expected %0d", bus.rem, e.rm); end
  endtask

  task automatic test_sequence;
    logic [7:0] av[4] = '{8'd255, 8'd200, 8'd5, 8'd0};
    logic [3:0] bv[4] = '{4'd15, 4'd7, 4'd9, 4'd1};
    logic [7:0] qx[4] = '{8'd17, 8'd28, 8'd0, 8'd0};
    logic [3:0] rx[4] = '{4'd0, 4'd4, 4'd5, 4'd0};
    int   cyc;
    bit   to;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_start(av[i], bv[i]);
      void'(sb.pop_back());
      sb.push_back('{q: qx[i], rm: rx[i], z: 1'b0});
      wait_done(cyc, to);
      e = sb.pop_front();
      checks++; if (to || cyc != 8) begin errors++; $display("[TB] FAIL seq%0d latency: got %0d (timeout %0d) expected 8", i, cyc, to); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("[TB] FAIL seq%0d quotient: got %0d expected %0d", i, bus.quotient, e.q); end
      checks++; if (bus.rem !== e.rm) begin errors++; $display("[TB] FAIL seq%0d rem: got %0d expected %0d", i, bus.rem, e.rm); end
    end
  endtask

  task automatic test_sweep;
    int   cyc;
    bit   to;
    exp_t e;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        drive_start(ai[7:0], bi[3:0]);
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++;
        if (to || bus.quotient !== e.q || bus.rem !== e.rm) begin
          errors++;
          $display("[TB] FAIL sweep %0d/%0d: got q=%0d r=%0d (timeout %0d) expected q=%0d r=%0d",
                   ai, bi, bus.quotient, bus.rem, to, e.q, e.rm);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] av[3] = '{8'd200, 8'd255, 8'd13};
    logic [3:0] bv[3] = '{4'd7, 4'd15, 4'd3};
    int   cyc;
    bit   to;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av[0];
    bus.b     = bv[0];
    sb.push_back(model(av[0], bv[0]));
    @(negedge clk);
    bus.a = 8'hAA;
    bus.b = 4'h1;
    for (int k = 0; k < 3; k++) begin
      wait_done(cyc, to);
      e = sb.pop_front();
      checks++; if (to || cyc != 8) begin errors++; $display("[TB] FAIL b2b%0d latency: got %0d (timeout %0d) expected 8", k, cyc, to); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("[TB] FAIL b2b%0d quotient: got %0d expected %0d", k, bus.quotient, e.q); end
      checks++; if (bus.rem !== e.rm) begin errors++; $display("[TB] FAIL b2b%0d rem: got %0d expected %0d", k, bus.rem, e.rm); end
      if (k < 2) begin
        bus.a = av[k+1];
        bus.b = bv[k+1];
        sb.push_back(model(av[k+1], bv[k+1]));
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b%0d restart: got busy=%b done=%b expected busy=1 done=0", k, bus.busy, bus.done); end
        bus.a = 8'h55;
        bus.b = 4'h2;
      end else begin
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b idle after stop: got busy=%b expected 0", bus.busy); end
      end
    end
  endtask

  task automatic test_ignore_start;
    int   cyc;
    bit   to;
    exp_t e;
    drive_start(8'd66, 4'd6);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'd0;
    bus.b     = 4'd0;
    wait_done(cyc, to);
    e = sb.pop_front();
    checks++; if (to || cyc != 6) begin errors++; $display("[TB] FAIL ignore latency: got %0d (timeout %0d) expected 6", cyc, to); end
    checks++; if (bus.quotient !== e.q) begin errors++; $display("[TB] FAIL ignore quotient: got %0d expected %0d", bus.quotient, e.q); end
    checks++; if (bus.rem !== e.rm) begin errors++; $display("[TB] FAIL ignore rem: got %0d expected %0d", bus.rem, e.rm); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore extra run: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_dbz;
    int   cyc;
    bit   to;
    int   lat;
    exp_t e;
`ifdef DIVIDER_DBZ_DETECT_EN
    lat = 1;
`else
    lat = 8;
`endif
    drive_start(8'd100, 4'd0);
    wait_done(cyc, to);
    e = sb.pop_front();
    checks++; if (to || cyc != lat) begin errors++; $display("[TB] FAIL dbz latency: got %0d (timeout %0d) expected %0d", cyc, to, lat); end
    checks++; if (bus.quotient !== e.q) begin errors++; $display("[TB] FAIL dbz quotient: got %h expected %h", bus.quotient, e.q); end
    checks++; if (bus.rem !== e.rm) begin errors++; $display("[TB] FAIL dbz rem: got %h expected %h", bus.rem, e.rm); end
    checks++; if (bus.dbz !== e.z) begin errors++; $display("[TB] FAIL dbz flag: got %b expected %b", bus.dbz, e.z); end
    drive_start(8'd66, 4'd6);
    checks++; if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL dbz clear on start: got %b expected 0", bus.dbz); end
    wait_done(cyc, to);
    e = sb.pop_front();
    checks++; if (to || bus.quotient !== e.q || bus.rem !== e.rm) begin errors++; $display("[TB] FAIL dbz followup: got q=%0d r=%0d (timeout %0d) expected q=%0d r=%0d", bus.quotient, bus.rem, to, e.q, e.rm); end
  endtask

  task automatic test_reset_mid_run;
    int   cyc;
    bit   to;
    bit   saw_done;
    exp_t e;
    drive_start(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort done: got %b expected 0", bus.done); end
    checks++; if (bus.quotient !== 8'h00) begin errors++; $display("[TB] FAIL abort quotient: got %h expected 00", bus.quotient); end
    checks++; if (bus.rem !== 4'h0) begin errors++; $display("[TB] FAIL abort rem: got %h expected 0", bus.rem); end
    checks++; if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL abort dbz: got %b expected 0", bus.dbz); end
    #1;
    rst_n = 1'b1;
    sb.delete();
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("[TB] FAIL abort activity: got done/busy after reset expected none"); end
    drive_start(8'd66, 4'd6);
    wait_done(cyc, to);
    e = sb.pop_front();
    checks++; if (to || cyc != 8) begin errors++; $display("[TB] FAIL post-reset latency: got %0d (timeout %0d) expected 8", cyc, to); end
    checks++; if (bus.quotient !== e.q || bus.rem !== e.rm) begin errors++; $display("[TB] FAIL post-reset result: got q=%0d r=%0d expected q=%0d r=%0d", bus.quotient, bus.rem, e.q, e.rm); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 4'h0;
    $display("[TB] divider_8by4 bench start");
    test_reset();
    test_basic();
    test_sequence();
    test_ignore_start();
    test_back_to_back();
    test_dbz();
    test_reset_mid_run();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
